// File: rtl/program_mem_pkg.sv
// program_mem_pkg
// Shared constants for the 16x128 program memory and the loader state
// encoding. The constants are also used by the RAM itself and by the
// instruction-fetch logic, so they live here rather than in any one block.
package program_mem_pkg;

  localparam int PROG_ADDR_W = 7;
  localparam int PROG_DATA_W = 16;
  localparam int PROG_DEPTH  = 128;

  typedef enum logic [2:0] {
    LD_IDLE       = 3'd0,
    LD_RECV_HI    = 3'd1,
    LD_RECV_LO    = 3'd2,
    LD_WRITE      = 3'd3,
    LD_VERIFY_REQ = 3'd4,
    LD_VERIFY_ACC = 3'd5,
    LD_DONE       = 3'd6
  } loader_state_e;

endpackage

// File: rtl/byte_to_word_packer.sv
// byte_to_word_packer
// Collects two bytes (high byte first) into one 16-bit word.
// Ports:
//   clk, rst     clock and synchronous active-high reset (word_valid only)
//   recv_hi      loader is waiting for the high byte
//   recv_lo      loader is waiting for the low byte
//   in_valid     byte source has data
//   in_data      byte payload
//   in_ready     byte accepted this cycle when in_valid is also high
//   word_valid   one-cycle strobe, high in the cycle after the low byte lands
//   word         {hi, lo}
module byte_to_word_packer
  import program_mem_pkg::*;
#(
  parameter int DATA_W = PROG_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              recv_hi,
  input  logic              recv_lo,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  logic [7:0] hi_q, hi_d;
  logic [7:0] lo_q, lo_d;
  logic       word_valid_q, word_valid_d;

  // Readiness is a pure decode of the loader state, so there is no
  // combinational path from in_valid back to in_ready.
  assign in_ready = recv_hi | recv_lo;

  always_comb begin
    hi_d         = hi_q;
    lo_d         = lo_q;
    word_valid_d = recv_lo & in_valid;
    if (recv_hi && in_valid) hi_d = in_data;
    if (recv_lo && in_valid) lo_d = in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) word_valid_q <= 1'b0;
    else     word_valid_q <= word_valid_d;
  end

  // Byte holding registers carry data only; they are never observed
  // unless word_valid is set, so they need no reset.
  always_ff @(posedge clk) begin
    hi_q <= hi_d;
    lo_q <= lo_d;
  end

  assign word_valid = word_valid_q;
  assign word       = {hi_q, lo_q};

endmodule

// File: rtl/program_loader.sv
// program_loader
// Streams bytes into the 16x128 program RAM as 16-bit words (MSB first),
// starting at address 0, then reads the region back and compares a 16-bit
// modulo sum of what was written against the sum of what was read.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, word_count begin a load of word_count words (0..128, saturating)
//   in_valid/in_data/in_ready   byte stream handshake
//   ram_write_en/ram_read_en/ram_addr/ram_din/ram_dout   RAM ports
//   busy              high outside IDLE
//   done              one-cycle pulse when the load completes
//   verify_err        readback sum differed; held until the next start
//   checksum          modulo-2^16 sum of the words written
module program_loader
  import program_mem_pkg::*;
#(
  parameter int ADDR_W = PROG_ADDR_W,
  parameter int DATA_W = PROG_DATA_W,
  parameter int DEPTH  = PROG_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              ram_write_en,
  output logic              ram_read_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              verify_err,
  output logic [DATA_W-1:0] checksum
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [DATA_W-1:0] rd_sum_q, rd_sum_d;
  logic              verify_err_q, verify_err_d;

  logic              word_valid;
  logic [DATA_W-1:0] word;

  // Index of the final word: count clamped to DEPTH, minus one. Only used
  // for non-zero counts, so the result always fits in ADDR_W bits.
  function automatic logic [ADDR_W-1:0] last_index(input logic [7:0] wc);
    logic [7:0] n;
    n = (wc > 8'(DEPTH)) ? 8'(DEPTH) : wc;
    return ADDR_W'(n - 8'd1);
  endfunction

  byte_to_word_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .recv_hi    (state_q == LD_RECV_HI),
    .recv_lo    (state_q == LD_RECV_LO),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    last_d       = last_q;
    checksum_d   = checksum_q;
    rd_sum_d     = rd_sum_q;
    verify_err_d = verify_err_q;

    unique case (state_q)
      LD_IDLE: begin
        if (start) begin
          ptr_d        = '0;
          checksum_d   = '0;
          rd_sum_d     = '0;
          verify_err_d = 1'b0;
          if (word_count == 8'd0) begin
            state_d = LD_DONE;
          end else begin
            last_d  = last_index(word_count);
            state_d = LD_RECV_HI;
          end
        end
      end
      LD_RECV_HI: if (in_valid) state_d = LD_RECV_LO;
      LD_RECV_LO: if (in_valid) state_d = LD_WRITE;
      LD_WRITE: begin
        if (word_valid) checksum_d = checksum_q + word;
        if (ptr_q == last_q) begin
          ptr_d   = '0;
          state_d = LD_VERIFY_REQ;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          state_d = LD_RECV_HI;
        end
      end
      LD_VERIFY_REQ: state_d = LD_VERIFY_ACC;
      LD_VERIFY_ACC: begin
        // ram_dout holds the word requested in the previous cycle.
        rd_sum_d = rd_sum_q + ram_dout;
        if (ptr_q == last_q) begin
          state_d = LD_DONE;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          state_d = LD_VERIFY_REQ;
        end
      end
      LD_DONE: state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase

    // Compare on the edge entering DONE, using the sums as they will be
    // after that edge so the final readback word is included.
    if (state_d == LD_DONE) verify_err_d = (rd_sum_d != checksum_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LD_IDLE;
      ptr_q        <= '0;
      last_q       <= '0;
      checksum_q   <= '0;
      rd_sum_q     <= '0;
      verify_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      last_q       <= last_d;
      checksum_q   <= checksum_d;
      rd_sum_q     <= rd_sum_d;
      verify_err_q <= verify_err_d;
    end
  end

  // Outputs decode state and registers only.
  assign busy         = (state_q != LD_IDLE);
  assign done         = (state_q == LD_DONE);
  assign ram_write_en = (state_q == LD_WRITE);
  assign ram_read_en  = (state_q == LD_VERIFY_REQ);
  assign ram_addr     = (ram_write_en || ram_read_en) ? ptr_q : '0;
  assign ram_din      = ram_write_en ? word : '0;
  assign verify_err   = verify_err_q;
  assign checksum     = checksum_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  import program_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        ram_write_en;
  logic        ram_read_en;
  logic [6:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic        busy;
  logic        done;
  logic        verify_err;
  logic [15:0] checksum;

  always #5 clk = ~clk;

  program_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .word_count   (word_count),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .ram_write_en (ram_write_en),
    .ram_read_en  (ram_read_en),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout),
    .busy         (busy),
    .done         (done),
    .verify_err   (verify_err),
    .checksum     (checksum)
  );

  // RAM model: synchronous write, registered read, optional bit-0 flip on addr 2.
  logic [15:0] mem [0:127];
  logic        corrupt;
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_addr] <= ram_din;
    if (ram_read_en)  ram_dout <= mem[ram_addr] ^ ((corrupt && ram_addr == 7'd2) ? 16'h0001 : 16'h0000);
  end

  int pe = 0;
  always @(posedge clk) pe <= pe + 1;

  // Activity log, relative to the edge that accepts start (cycle 0).
  int          p0, wr_n, rd_n, done_n, done_cyc, both_n;
  int          wr_cyc  [0:255];
  logic [6:0]  wr_addr [0:255];
  logic [15:0] wr_data [0:255];
  always @(negedge clk) begin
    if (start && !busy && !rst) begin
      p0       <= pe + 1;
      wr_n     <= 0;
      rd_n     <= 0;
      done_n   <= 0;
      done_cyc <= -1;
      both_n   <= 0;
    end else begin
      if (ram_write_en && wr_n < 256) begin
        wr_cyc[wr_n]  <= pe - p0 + 1;
        wr_addr[wr_n] <= ram_addr;
        wr_data[wr_n] <= ram_din;
        wr_n          <= wr_n + 1;
      end
      if (ram_read_en) rd_n <= rd_n + 1;
      if (ram_write_en && ram_read_en) both_n <= both_n + 1;
      if (done) begin
        done_n   <= done_n + 1;
        done_cyc <= pe - p0 + 1;
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [7:0] bytes [0:255];

  task automatic set_basic();
    bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'hAB; bytes[3] = 8'hCD;
    bytes[4] = 8'h00; bytes[5] = 8'h01; bytes[6] = 8'hFF; bytes[7] = 8'hFF;
  endtask

  // Presents bytes in order; entered and left just after a rising edge.
  task automatic feed(input int nbytes, input bit gaps, output int idle);
    int  i;
    int  guard;
    bit  tog;
    bit  hs;
    i = 0; guard = 0; tog = 1'b1; idle = 0;
    while (i < nbytes && guard < 5000) begin
      in_valid = gaps ? tog : 1'b1;
      in_data  = bytes[i];
      @(negedge clk);
      hs = in_ready && in_valid;
      if (in_ready && !in_valid) idle++;
      @(posedge clk); #1;
      if (hs) i++;
      tog = ~tog;
      guard++;
    end
    in_valid = 1'b0;
    if (i < nbytes) check_eq("feed_timeout", 32'(i), 32'(nbytes));
  endtask

  task automatic pulse_start(input logic [7:0] wc);
    start = 1'b1; word_count = wc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_n > 0) break;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  int idle;
  int exp_sum;
  logic [15:0] basic_w [0:3];

  initial begin
    basic_w[0] = 16'h1234; basic_w[1] = 16'hABCD; basic_w[2] = 16'h0001; basic_w[3] = 16'hFFFF;
    rst = 1'b1; start = 1'b0; word_count = 8'd0; in_valid = 1'b0; in_data = 8'd0;
    corrupt = 1'b0; ram_dout = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy",     32'(busy), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_strobes",  32'({ram_write_en, ram_read_en, done, verify_err}), 32'd0);
    check_eq("rst_addr_din", 32'({ram_addr, ram_din}), 32'd0);
    check_eq("rst_checksum", 32'(checksum), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic load, in_valid held high.
    set_basic();
    pulse_start(8'd4);
    feed(8, 1'b0, idle);
    wait_done();
    check_eq("basic_wr_n", 32'(wr_n), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check_eq("basic_wr_addr", 32'(wr_addr[k]), 32'(k));
      check_eq("basic_wr_data", 32'(wr_data[k]), 32'(basic_w[k]));
      check_eq("basic_wr_cyc",  32'(wr_cyc[k]), 32'(3 * k + 3));
    end
    check_eq("basic_checksum", 32'(checksum), 32'hBE01);
    check_eq("basic_done_n",   32'(done_n), 32'd1);
    check_eq("basic_done_cyc", 32'(done_cyc), 32'd21);
    check_eq("basic_verr",     32'(verify_err), 32'd0);
    check_eq("basic_rd_n",     32'(rd_n), 32'd4);
    check_eq("basic_both",     32'(both_n), 32'd0);

    // Same data with in_valid low every other cycle.
    for (int k = 0; k < 4; k++) mem[k] = 16'h0;
    pulse_start(8'd4);
    feed(8, 1'b1, idle);
    wait_done();
    check_eq("gap_idle_nonzero", 32'(idle > 0), 32'd1);
    check_eq("gap_done_cyc", 32'(done_cyc), 32'(21 + idle));
    check_eq("gap_checksum", 32'(checksum), 32'hBE01);
    for (int k = 0; k < 4; k++) check_eq("gap_mem", 32'(mem[k]), 32'(basic_w[k]));
    check_eq("gap_verr", 32'(verify_err), 32'd0);

    // Corrupted readback of addr 2.
    corrupt = 1'b1;
    pulse_start(8'd4);
    feed(8, 1'b0, idle);
    wait_done();
    check_eq("corrupt_verr",     32'(verify_err), 32'd1);
    check_eq("corrupt_checksum", 32'(checksum), 32'hBE01);
    corrupt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("corrupt_verr_held", 32'(verify_err), 32'd1);

    // Next start (zero count) clears it; done in cycle 1, no RAM strobes.
    pulse_start(8'd0);
    @(negedge clk);
    check_eq("zero_verr_cleared", 32'(verify_err), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("zero_done_cyc",  32'(done_cyc), 32'd1);
    check_eq("zero_done_n",    32'(done_n), 32'd1);
    check_eq("zero_strobes",   32'(wr_n + rd_n), 32'd0);
    check_eq("zero_checksum",  32'(checksum), 32'd0);
    check_eq("zero_verr",      32'(verify_err), 32'd0);

    // start pulsed mid-load with a different count is ignored.
    pulse_start(8'd4);
    fork
      feed(8, 1'b0, idle);
      begin
        repeat (5) @(posedge clk);
        #2 start = 1'b1; word_count = 8'd9;
        @(posedge clk);
        #2 start = 1'b0;
      end
    join
    wait_done();
    check_eq("busy_wr_n",     32'(wr_n), 32'd4);
    check_eq("busy_last_addr", 32'(wr_addr[3]), 32'd3);
    check_eq("busy_done_cyc", 32'(done_cyc), 32'd21);
    check_eq("busy_checksum", 32'(checksum), 32'hBE01);

    // Full depth, words 0..127 (also exercises >128 saturation).
    exp_sum = 0;
    for (int k = 0; k < 128; k++) begin
      bytes[2 * k]     = 8'h00;
      bytes[2 * k + 1] = 8'(k);
      exp_sum          = exp_sum + k;
    end
    pulse_start(8'd200);
    feed(256, 1'b0, idle);
    wait_done();
    check_eq("full_wr_n",       32'(wr_n), 32'd128);
    check_eq("full_last_addr",  32'(wr_addr[127]), 32'd127);
    check_eq("full_last_cyc",   32'(wr_cyc[127]), 32'd384);
    check_eq("full_mem127",     32'(mem[127]), 32'd127);
    check_eq("full_checksum",   32'(checksum), 32'(exp_sum[15:0]));
    check_eq("full_done_cyc",   32'(done_cyc), 32'd641);
    check_eq("full_verr",       32'(verify_err), 32'd0);
    check_eq("full_both",       32'(both_n), 32'd0);

    // Reset after word 2 is written.
    in_data  = 8'hA5;
    pulse_start(8'd8);
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_n >= 3) break;
    end
    check_eq("rstmid_reached", 32'(wr_n), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstmid_busy",     32'(busy), 32'd0);
    check_eq("rstmid_in_ready", 32'(in_ready), 32'd0);
    check_eq("rstmid_checksum", 32'(checksum), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("rstmid_no_wr",   32'(wr_n), 32'd3);
    check_eq("rstmid_no_rd",   32'(rd_n), 32'd0);
    check_eq("rstmid_no_done", 32'(done_n), 32'd0);
    for (int k = 0; k < 3; k++) check_eq("rstmid_mem", 32'(mem[k]), 32'hA5A5);
    check_eq("rstmid_mem3", 32'(mem[3]), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
